fp_add_arbiter: RTL
===================

// Module: fp_add_arbiter
// PURPOSE
//  Shares one floating-point add unit (32-bit format: sign[31], exp[30:25] bias 31, mantissa[24:0])
//  among NREQ requesters. Round-robin arbitration, valid/ready request handshake, start/done
//  sequencing of the unit, and result/status routing back to the owner. Sits between the
//  requesters and the PontosFlutuantes unit, one clock domain.
// PARAMETERS
//  NREQ         4    number of requesters (2..8)
//  WDOG_CYCLES  64   watchdog limit in cycles (used only with FPA_WATCHDOG_EN)
// PORTS
//  clock_100kHz  in   1          system clock, rising edge
//  reset         in   1          asynchronous, active-low reset
//  req_valid     in   NREQ       requester i has an operand pair pending
//  req_ready     out  NREQ       one-hot accept; handshake = req_valid[i] & req_ready[i]
//  req_op_a      in   NREQ*32    operand A of requester i at [32*i +: 32]
//  req_op_b      in   NREQ*32    operand B of requester i at [32*i +: 32]
//  rsp_valid     out  NREQ       one-hot, 1-cycle result strobe to the owner
//  rsp_data      out  32         result, valid while rsp_valid != 0
//  rsp_status    out  4          status: {inexact, underflow, overflow, exact}; 4'hF = timeout
//  fpu_start     out  1          1-cycle start pulse to the add unit
//  fpu_op_a      out  32         operand A to the unit, held from ISSUE through WAIT
//  fpu_op_b      out  32         operand B to the unit, held from ISSUE through WAIT
//  fpu_done      in   1          unit result valid (1-cycle pulse, >=1 cycle after start)
//  fpu_data      in   32         unit result
//  fpu_status    in   4          unit status
//  busy          out  1          1 in any state other than IDLE
//  ops_count     out  16         completed responses, wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, rr pointer 0; ops_count 0. All of the following are 0:
//   req_ready, rsp_valid, rsp_data, rsp_status, fpu_start, fpu_op_a/b, busy.
//   An in-flight op is discarded. No response is generated for it.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: req_ready is combinational, one-hot at grant g. g is the first i with req_valid[i],
//   searching from the rr pointer upward with wrap-around; req_ready is 0 if no request.
//   At the handshake edge: latch req_op_a/b[g] into fpu_op_a/b, latch owner id = g, go to ISSUE.
//  ISSUE: fpu_start=1 for exactly this cycle, then go to WAIT.
//  WAIT: fpu_done is sampled only here. On fpu_done, register fpu_data/status into
//   rsp_data/rsp_status and go to RESP. fpu_done in IDLE/ISSUE/RESP is ignored.
//  RESP: rsp_valid[id]=1 for one cycle; ops_count+1; rr pointer <= (id+1) mod NREQ; go to IDLE.
//   rsp_data/status hold their values until the next RESP.
//  Latency: handshake at edge k -> fpu_start in cycle k+1. fpu_done at edge d -> rsp_valid in
//   cycle d+1. Back-to-back throughput is one op per (FPU latency + 3) cycles.
//  Fairness: the requester just served has the lowest priority in the next arbitration.
//   A continuously valid requester is served within NREQ ops.
//  req_valid may drop before the handshake with no effect. Operands are sampled only at the handshake.
//  Reset mid-operation: immediate return to IDLE; rsp_valid never pulses for the lost op.
// CONFIGURATION
//  FPA_WATCHDOG_EN defined: cycle counter cleared on entry to WAIT. If WDOG_CYCLES cycles
//   pass in WAIT without fpu_done, go to RESP with rsp_data=0 and rsp_status=4'hF.
//   This counts in ops_count. A late fpu_done after that is ignored.
//  FPA_WATCHDOG_EN undefined: no counter, WAIT waits indefinitely, WDOG_CYCLES is unused.
// TESTING
//  1 Reset: assert reset=0 mid-WAIT -> all outputs 0 at once; no rsp_valid after release.
//  2 Single op: req0 A=32'h3E000000 (1.0), B=32'h40000000 (2.0), FPU model latency 5 ->
//     fpu_start 1 cycle after handshake; rsp_valid=4'b0001, rsp_data=32'h41000000 (3.0),
//     rsp_status=4'b0001.
//  3 Round-robin: all 4 valid continuously -> grant order 0,1,2,3,0; ops_count=5.
//  4 Wrap/priority: pointer=3, req_valid=4'b1001 -> grant 3, then 0; req1 raised later -> 1 next.
//  5 Spurious done: fpu_done pulsed in IDLE and ISSUE -> ignored; the result comes from the WAIT done.
//  6 Watchdog (FPA_WATCHDOG_EN, WDOG_CYCLES=8): FPU never done -> rsp_status=4'hF, rsp_data=0
//     8 cycles after WAIT entry; without the macro, busy stays 1.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one floating-point add unit among NREQ requesters.
//   Round-robin grant over req_valid, valid/ready accept, one-cycle start
//   pulse to the unit, result/status routed back to the owning requester.
//   Sequence per op: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional feature: define FPA_WATCHDOG_EN to abort a WAIT that lasts
//   WDOG_CYCLES cycles (result 0, status 4'hF). Without it WAIT is unbounded.
// Ports:
//   clock_100kHz, reset            clock (rising edge), async active-low reset
//   req_valid/req_ready            per-requester handshake (ready is one-hot)
//   req_op_a/req_op_b              packed operands, requester i at [32*i +: 32]
//   rsp_valid/rsp_data/rsp_status  one-hot 1-cycle strobe, held result/status
//   fpu_start/fpu_op_a/fpu_op_b    start pulse and held operands to the unit
//   fpu_done/fpu_data/fpu_status   unit result, sampled only in WAIT
//   busy, ops_count                not-IDLE flag, completed-response counter
module fp_add_arbiter #(
  parameter int NREQ        = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                 clock_100kHz,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_op_a,
  input  logic [NREQ*32-1:0]   req_op_b,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic [3:0]           rsp_status,
  output logic                 fpu_start,
  output logic [31:0]          fpu_op_a,
  output logic [31:0]          fpu_op_b,
  input  logic                 fpu_done,
  input  logic [31:0]          fpu_data,
  input  logic [3:0]           fpu_status,
  output logic                 busy,
  output logic [15:0]          ops_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [IW-1:0] rr;       // search start for the next arbitration
  logic [IW-1:0] id;       // owner of the op in flight
  logic [IW-1:0] gnt;
  logic          gnt_vld;
  logic [IW:0]   cand;
  logic [31:0]   sel_a, sel_b;
  logic [IW-1:0] id_nxt;
  logic          hs;
  logic          wdog_hit;

  // Round-robin search: walk downward so the lowest offset from rr wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int j = NREQ-1; j >= 0; j--) begin
      cand = {1'b0, rr} + (IW+1)'(j);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (req_valid[cand[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IW'(i)) begin
        sel_a = req_op_a[32*i +: 32];
        sel_b = req_op_b[32*i +: 32];
      end
    end
  end

  // Ready is gated with reset so nothing is accepted while reset is held.
  assign hs        = (state == IDLE) && gnt_vld && reset;
  assign req_ready = hs ? (NREQ'(1) << gnt) : '0;
  assign id_nxt    = (id == IW'(NREQ-1)) ? '0 : id + 1'b1;

`ifdef FPA_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES+1);
  logic [CW-1:0] wdog;
  assign wdog_hit = (wdog == CW'(WDOG_CYCLES-1));
`else
  logic [31:0] unused_wdog;
  assign unused_wdog = WDOG_CYCLES;
  assign wdog_hit    = 1'b0;
`endif

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr         <= '0;
      id         <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_status <= '0;
      fpu_start  <= 1'b0;
      fpu_op_a   <= '0;
      fpu_op_b   <= '0;
      busy       <= 1'b0;
      ops_count  <= '0;
`ifdef FPA_WATCHDOG_EN
      wdog       <= '0;
`endif
    end else begin
      fpu_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (hs) begin
            fpu_op_a  <= sel_a;
            fpu_op_b  <= sel_b;
            id        <= gnt;
            fpu_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef FPA_WATCHDOG_EN
          wdog  <= '0;
`endif
        end
        WAIT: begin
          // A real done on the same edge as the timeout takes precedence.
          if (fpu_done) begin
            rsp_data   <= fpu_data;
            rsp_status <= fpu_status;
            rsp_valid  <= NREQ'(1) << id;
            state      <= RESP;
          end else if (wdog_hit) begin
            rsp_data   <= '0;
            rsp_status <= 4'hF;
            rsp_valid  <= NREQ'(1) << id;
            state      <= RESP;
          end
`ifdef FPA_WATCHDOG_EN
          else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        RESP: begin
          ops_count <= ops_count + 16'd1;
          rr        <= id_nxt;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
